ps2_key_rx: RTL

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync_filter.sv | 35 +++
 rtl/ps2_key_rx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - frame states, prefix bytes and filler-byte helper for the PS/2 key receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keyboard status/ack codes that never represent a key
  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-flop synchronizer plus FILT_LEN-cycle stability filter for one PS/2 line
module ps2_sync_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic RESET_N,
  input  logic line_raw,
  output logic level
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], line_raw};
      // A new level is taken only after FILT_LEN consecutive disagreeing samples
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver and scancode decoder; PS2_PARITY_EN enables parity rejection
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_f, dat_f, clk_prev, strobe, frame_ok;
  ps2_state_t    state;
  logic [2:0]    bit_cnt, skip;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo;
  logic          ext, brk;
`ifdef PS2_PARITY_EN
  logic          par_ok;
`endif

  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .line_raw(ps2_clk), .level(clk_f)
  );
  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .line_raw(ps2_dat), .level(dat_f)
  );

  assign strobe = clk_prev & ~clk_f;

  always_comb begin
    frame_ok = dat_f;
`ifdef PS2_PARITY_EN
    frame_ok = dat_f & par_ok;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      clk_prev  <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      tmo       <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip      <= '0;
      ps2_key   <= '0;
      key_stb   <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_PARITY_EN
      par_ok    <= 1'b0;
`endif
    end else begin
      clk_prev  <= clk_f;
      key_stb   <= 1'b0;
      frame_err <= 1'b0;
      // A strobe always restarts the inter-edge timer, even if it coincides with expiry
      if (strobe) begin
        tmo <= '0;
        case (state)
          ST_IDLE: begin
            if (!dat_f) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_EN
            par_ok <= ^{shreg, dat_f};
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (skip != 3'd0) begin
              skip <= skip - 1'b1;
            end else if (shreg == PFX_PAUSE) begin
              skip <= PAUSE_SKIP;
            end else if (shreg == PFX_EXT) begin
              ext <= 1'b1;
            end else if (shreg == PFX_BRK) begin
              brk <= 1'b1;
            end else if (!(is_filler(shreg) && !ext && !brk)) begin
              ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
              key_stb <= 1'b1;
              ext     <= 1'b0;
              brk     <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          state     <= ST_IDLE;
          frame_err <= 1'b1;
          tmo       <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

endmodule
